rom_mul8_sequencer: RTL
=======================

// Module: rom_mul8_sequencer
// PURPOSE
//  Sequences the 4x4 nibble-product lookup ROM (addr = {x[3:0], y[3:0]}, data = x*y)
//  to compute an unsigned OP_W x OP_W multiply by shift-and-accumulate of nibble partial products.
//  Sits between a requesting datapath (start/done handshake) and the shared product ROM.
//  Issues one ROM lookup per cycle; result is held in a product register until the next completion.
// PARAMETERS
//  OP_W     8  operand width in bits; multiple of 4; K = OP_W/4 nibbles per operand
//  ROM_LAT  0  ROM read latency in cycles: 0 = combinational ROM, 1 = registered ROM
// PORTS
//  clk       in   1        system clock, rising edge
//  rst       in   1        asynchronous, active-high reset
//  start     in   1        request; sampled only when busy=0
//  a         in   OP_W     multiplicand, latched on accepted start
//  b         in   OP_W     multiplier, latched on accepted start
//  rom_req   out  1        high in cycles where rom_addr carries a valid lookup
//  rom_addr  out  8        {a_nibble, b_nibble} lookup address to product ROM
//  rom_data  in   8        nibble product returned by ROM (ROM_LAT cycles after rom_addr)
//  busy      out  1        operation in progress (RUN or DRAIN)
//  done      out  1        one-cycle pulse: product valid and updated
//  product   out  2*OP_W   last completed result a*b
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy, done, rom_req, rom_addr, product, acc, idx all 0.
//  States: IDLE, RUN, DRAIN (present only when ROM_LAT=1), DONE.
//  IDLE/DONE: busy=0; start=1 -> latch a,b; acc<=0; idx<=0; go RUN. start while busy=1 ignored.
//  RUN: idx = 0..K*K-1; i = idx / K (a nibble, outer), j = idx % K (b nibble, inner).
//   rom_addr = {a_l[4i+3:4i], b_l[4j+3:4j]}, rom_req=1.
//   Accumulate: acc += zero-extended rom_data << 4*(i+j), using the i,j of the lookup that produced
//   that data (delay i+j by ROM_LAT cycles in a shift tag pipeline).
//   idx = K*K-1 -> DONE if ROM_LAT=0, else DRAIN.
//  DRAIN: rom_req=0, rom_addr=0; accumulate final returning data; -> DONE.
//  On the RUN/DRAIN -> DONE edge: product <= final acc (including last partial product).
//  DONE: done=1 for exactly one cycle; -> IDLE, or -> RUN if start=1 (back-to-back accepted).
//  Timing: start accepted at edge E0; busy=1 from E0; done=1 in the cycle following edge
//   E0 + K*K + ROM_LAT; busy=0 in that done cycle. Default (K=2, LAT=0): done 4 cycles after E0.
//  rom_req=0 and rom_addr=0 outside lookup cycles.
//  Width: acc and product are 2*OP_W bits; max sum equals (2^OP_W-1)^2, so no overflow or truncation.
//  a and b are sampled only at accept; changes during RUN have no effect.
//  product holds its value across IDLE and during the next operation until that operation's done.
//  Reset mid-operation: operation abandoned; no done pulse; next start runs normally from idx 0.
// TESTING
//  1 a=8'h12, b=8'h34, LAT=0 -> rom_addr 8'h24, 8'h23, 8'h14, 8'h13 on consecutive cycles;
//    product=16'h03A8; done 4 cycles after the start edge.
//  2 a=8'hFF, b=8'hFF -> product=16'hFE01, single done pulse, busy low in the done cycle.
//  3 start a=8'h0A, b=8'h0B, then start=1 with a=8'hFF, b=8'hFF while busy -> product=16'h006E,
//    exactly one done pulse.
//  4 start a=3, b=5, then start held high in the done cycle with a=8'h10, b=8'h10 -> 16'h000F,
//    then 16'h0100; done pulses 5 cycles apart.
//  5 rst pulsed mid-RUN (idx=2) -> busy/done/rom_req/rom_addr/product =0 immediately, no done;
//    then a=7, b=9 -> 16'h003F.
//  6 ROM_LAT=1 with registered ROM model; 1000 random a,b compared to a*b; done 5 cycles
//    after each start edge.

Source files
------------

// File: rtl/rom_mul8_sequencer_if.sv
// Handshake and ROM bus for rom_mul8_sequencer.
//   start/a/b     : request side, operands latched when start is accepted
//   rom_req/addr  : lookup issued to the shared nibble-product ROM
//   rom_data      : nibble product returned by the ROM
//   busy/done     : operation in progress / one-cycle completion pulse
//   product       : last completed a*b
// slave  = the sequencer; master = requester plus ROM environment.
interface rom_mul8_sequencer_if #(
  parameter int OP_W = 8
);
  logic                start;
  logic [OP_W-1:0]     a;
  logic [OP_W-1:0]     b;
  logic                rom_req;
  logic [7:0]          rom_addr;
  logic [7:0]          rom_data;
  logic                busy;
  logic                done;
  logic [2*OP_W-1:0]   product;

  modport slave (
    input  start, a, b, rom_data,
    output rom_req, rom_addr, busy, done, product
  );

  modport master (
    output start, a, b, rom_data,
    input  rom_req, rom_addr, busy, done, product
  );
endinterface

// File: rtl/rom_mul8_sequencer.sv
// Unsigned OP_W x OP_W multiplier built by sequencing a 4x4 nibble-product
// ROM (addr = {x, y}, data = x*y) and shift-accumulating the partial products.
// One lookup per cycle, K*K lookups per operation (K = OP_W/4).
// Ports: clk, rst (async, active high), bus (rom_mul8_sequencer_if.slave).
// ROM_LAT = 0 for a combinational ROM, 1 for a registered ROM.
module rom_mul8_sequencer #(
  parameter int OP_W    = 8,
  parameter int ROM_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_mul8_sequencer_if.slave   bus
);

  localparam int K     = OP_W / 4;
  localparam int IW    = (K > 1) ? $clog2(K) : 1;
  localparam int SHW   = (K > 1) ? $clog2(2 * K - 1) : 1;
  localparam int ACC_W = 2 * OP_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]      ai_q, ai_d, bj_q, bj_d;
  logic [ACC_W-1:0]   acc_q, acc_d, product_q, product_d, acc_sum;
  logic               tag_vld_q, tag_vld_d;
  logic [SHW-1:0]     tag_sh_q, tag_sh_d, cur_sh, add_sh;
  logic               add_en, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ai_q      <= '0;
      bj_q      <= '0;
      acc_q     <= '0;
      product_q <= '0;
      tag_vld_q <= 1'b0;
      tag_sh_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ai_q      <= ai_d;
      bj_q      <= bj_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      tag_vld_q <= tag_vld_d;
      tag_sh_q  <= tag_sh_d;
    end
  end

  always_comb begin
    cur_sh = SHW'(ai_q) + SHW'(bj_q);
    last   = (ai_q == IW'(K - 1)) && (bj_q == IW'(K - 1));

    // With a registered ROM the data in this cycle belongs to the previous
    // lookup, so its shift comes from the one-deep tag pipeline.
    add_en  = (ROM_LAT == 0) ? (state_q == RUN) : tag_vld_q;
    add_sh  = (ROM_LAT == 0) ? cur_sh : tag_sh_q;
    acc_sum = acc_q + (ACC_W'(bus.rom_data) << {add_sh, 2'b00});

    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ai_d      = ai_q;
    bj_d      = bj_q;
    acc_d     = add_en ? acc_sum : acc_q;
    product_d = product_q;
    tag_vld_d = (state_q == RUN);
    tag_sh_d  = cur_sh;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          ai_d    = '0;
          bj_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bj_q == IW'(K - 1)) begin
          bj_d = '0;
          ai_d = ai_q + IW'(1);
        end else begin
          bj_d = bj_q + IW'(1);
        end
        if (last) begin
          if (ROM_LAT == 0) begin
            product_d = acc_sum;
            state_d   = DONE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        product_d = acc_sum;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == RUN) || (state_q == DRAIN);
    bus.done     = (state_q == DONE);
    bus.rom_req  = (state_q == RUN);
    bus.rom_addr = bus.rom_req ? {a_q[{ai_q, 2'b00} +: 4], b_q[{bj_q, 2'b00} +: 4]} : '0;
    bus.product  = product_q;
  end

endmodule
